// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings and helpers for the byte-serial memory controller
package mem_ctrl_pkg;

  localparam logic [31:0] IO_BASE = 32'h00030000;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_LSB} owner_t;

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == IO_BASE[17:16];
  endfunction

  // The reserved size code 2'b11 falls through to a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - requester and RAM-port signals of the memory controller
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_wr;
  logic [31:0] lsb_addr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    output if_req, if_addr, lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata,
           mem_din, io_buffer_full,
    input  if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_req, if_addr, lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata,
           mem_din, io_buffer_full,
    output if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates IF and LSB onto the 8-bit RAM/IO port, little-endian byte sequencing
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      flush_in,
  mem_ctrl_if.slave bus
);

  state_t      state;
  owner_t      owner;
  logic [31:0] base, wbuf, rbuf, rbuf_next, next_a;
  logic [2:0]  n, pcnt, ccnt;
  logic        av, dv;
  logic [1:0]  nidx;
  logic [7:0]  next_byte;
  logic [31:0] mem_a_q, if_data_q, lsb_rdata_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q, if_done_q, lsb_done_q;

  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;

  // av: mem_a this cycle names a wanted byte; dv: mem_din this cycle carries byte ccnt.
  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[{ccnt[1:0], 3'b000} +: 8] = bus.mem_din;
  end

  assign nidx      = ccnt[1:0] + 2'd1;
  assign next_a    = base + {29'd0, ccnt} + 32'd1;
  assign next_byte = wbuf[{nidx, 3'b000} +: 8];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      owner       <= OWN_IF;
      base        <= '0;
      wbuf        <= '0;
      rbuf        <= '0;
      n           <= '0;
      pcnt        <= '0;
      ccnt        <= '0;
      av          <= 1'b0;
      dv          <= 1'b0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (!rdy_in) begin
      mem_wr_q <= 1'b0;
      // The byte on mem_din during a pause is dropped, so restart at the first uncaptured byte.
      if (state == ST_READ) begin
        mem_a_q <= base + {29'd0, ccnt};
        pcnt    <= ccnt + 3'd1;
        av      <= 1'b1;
        dv      <= 1'b0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!flush_in && (bus.lsb_req || bus.if_req)) begin
            pcnt <= 3'd1;
            ccnt <= 3'd0;
            rbuf <= '0;
            av   <= 1'b1;
            dv   <= 1'b0;
            if (bus.lsb_req) begin
              owner   <= OWN_LSB;
              base    <= bus.lsb_addr;
              n       <= size_bytes(bus.lsb_size);
              wbuf    <= bus.lsb_wdata;
              mem_a_q <= bus.lsb_addr;
              if (bus.lsb_wr) begin
                state      <= ST_WRITE;
                mem_dout_q <= bus.lsb_wdata[7:0];
                mem_wr_q   <= !(bus.io_buffer_full && is_io(bus.lsb_addr));
              end else begin
                state <= ST_READ;
              end
            end else begin
              owner   <= OWN_IF;
              base    <= bus.if_addr;
              n       <= 3'd4;
              mem_a_q <= bus.if_addr;
              state   <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (flush_in) begin
            state   <= ST_IDLE;
            mem_a_q <= '0;
            av      <= 1'b0;
            dv      <= 1'b0;
          end else if (dv && (ccnt + 3'd1 == n)) begin
            state   <= ST_DONE;
            mem_a_q <= '0;
            av      <= 1'b0;
            dv      <= 1'b0;
            if (owner == OWN_IF) begin
              if_done_q <= 1'b1;
              if_data_q <= rbuf_next;
            end else begin
              lsb_done_q  <= 1'b1;
              lsb_rdata_q <= rbuf_next;
            end
          end else begin
            if (dv) begin
              rbuf <= rbuf_next;
              ccnt <= ccnt + 3'd1;
            end
            dv <= av;
            if (pcnt < n) begin
              mem_a_q <= base + {29'd0, pcnt};
              pcnt    <= pcnt + 3'd1;
              av      <= 1'b1;
            end else begin
              av <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          // A cycle with mem_wr low wrote nothing, so the same byte is offered again.
          if (mem_wr_q) begin
            if (ccnt + 3'd1 == n) begin
              state      <= ST_DONE;
              lsb_done_q <= 1'b1;
              mem_wr_q   <= 1'b0;
              mem_a_q    <= '0;
              mem_dout_q <= '0;
            end else begin
              ccnt       <= ccnt + 3'd1;
              mem_a_q    <= next_a;
              mem_dout_q <= next_byte;
              mem_wr_q   <= !(bus.io_buffer_full && is_io(next_a));
            end
          end else begin
            mem_wr_q <= !(bus.io_buffer_full && is_io(mem_a_q));
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          if_done_q   <= 1'b0;
          lsb_done_q  <= 1'b0;
          if_data_q   <= '0;
          lsb_rdata_q <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
